// File: rtl/cdbus_rx_pkg.sv
// Shared definitions for the CDBUS bit-level receiver: one-hot FSM states,
// CRC-16 constants and the per-byte CRC update helper.
package cdbus_rx_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_START     = 5'b00010,
    ST_DATA      = 5'b00100,
    ST_STOP      = 5'b01000,
    ST_WAIT_HIGH = 5'b10000
  } rx_state_e;

  localparam logic [15:0] CRC_POLY     = 16'hA001;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [9:0]  IDLE_CNT_MAX = 10'd1023;

  // Reflected CRC-16 update over one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Loadable bit-period down-counter. An explicit load sets the count (used for
// the half-bit offset to the start-bit centre); on reaching zero it emits a
// one-cycle expiry pulse and reloads the current divider, so a divider change
// only takes effect at the next reload.
module rx_bit_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic [15:0] div_i,
  output logic        expire_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: explicit load wins, otherwise count down and auto-reload.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q == 16'd0) begin
      cnt_d    = div_i;
      expire_o = 1'b1;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_des_frame.sv
// CDBUS receive deserializer: synchronizes the rx pin, recovers UART-style
// bytes (first byte of a frame at div_ls, later bytes at div_hs), flags
// breaks and framing errors, detects bus idle / frame end and keeps a running
// CRC-16 over the delivered bytes of the current frame.
// Optional: define RX_GLITCH_FILTER_EN to add a 3-sample majority filter
// (one extra cycle of latency, rejects single-cycle pulses).
module rx_des_frame
  import cdbus_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic [15:0] div_ls,
  input  logic [15:0] div_hs,
  input  logic [9:0]  idle_len,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        break_det,
  output logic        frame_err,
  output logic        frame_end,
  output logic        bus_idle,
  output logic [15:0] crc_data
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync_s;
  logic                   rx_s;

  // Input synchronizer chain; idle-high reset value avoids a false start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_sync_s = sync_q[SYNC_STAGES-1];

`ifdef RX_GLITCH_FILTER_EN
  logic [1:0] filt_q;

  // History of the two previous synchronized samples for the majority vote.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 2'b11;
    end else begin
      filt_q <= {filt_q[0], rx_sync_s};
    end
  end

  assign rx_s = (rx_sync_s & filt_q[0]) | (rx_sync_s & filt_q[1]) |
                (filt_q[0] & filt_q[1]);
`else
  assign rx_s = rx_sync_s;
`endif

  rx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        break_q, break_d;
  logic        ferr_q, ferr_d;
  logic        fend_q, fend_d;
  logic        bus_idle_q, bus_idle_d;
  logic [15:0] crc_q, crc_d;
  logic        in_frame_q, in_frame_d;
  logic        baud_sel_q, baud_sel_d;
  logic [15:0] idle_tmr_q, idle_tmr_d;
  logic [9:0]  idle_cnt_q, idle_cnt_d;
  logic        rx_prev_q;

  logic [15:0] div_s;
  logic        tmr_load_s;
  logic [15:0] tmr_load_val_s;
  logic        tmr_expire_s;
  logic [9:0]  idle_thr_s;

  assign div_s = baud_sel_q ? div_hs : div_ls;

  rx_bit_timer u_bit_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_load_val_s),
    .div_i      (div_s),
    .expire_o   (tmr_expire_s)
  );

  // Next-state, byte assembly, strobes, CRC and idle tracking.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    byte_data_d    = byte_data_q;
    byte_valid_d   = 1'b0;
    break_d        = 1'b0;
    ferr_d         = 1'b0;
    fend_d         = 1'b0;
    crc_d          = crc_q;
    in_frame_d     = in_frame_q;
    baud_sel_d     = baud_sel_q;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = {1'b0, div_s[15:1]};
    idle_tmr_d     = idle_tmr_q;
    idle_cnt_d     = idle_cnt_q;
    idle_thr_s     = idle_len;
    bus_idle_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s && rx_prev_q) begin
          state_d    = ST_START;
          tmr_load_s = 1'b1;
          if (!in_frame_q) begin
            crc_d = CRC_INIT;
          end else begin
            crc_d = crc_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tmr_expire_s) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tmr_expire_s) begin
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tmr_expire_s) begin
          if (rx_s) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            crc_d        = crc16_byte(crc_q, shift_q);
            in_frame_d   = 1'b1;
            baud_sel_d   = 1'b1;
            state_d      = ST_IDLE;
          end else if (shift_q == 8'h00) begin
            break_d    = 1'b1;
            in_frame_d = 1'b0;
            baud_sel_d = 1'b0;
            state_d    = ST_WAIT_HIGH;
          end else begin
            ferr_d     = 1'b1;
            in_frame_d = 1'b0;
            baud_sel_d = 1'b0;
            state_d    = ST_WAIT_HIGH;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Idle time is always measured in low-speed bit periods.
    if ((state_q == ST_IDLE) && rx_s) begin
      if (idle_tmr_q >= div_ls) begin
        idle_tmr_d = 16'd0;
        if (idle_cnt_q != IDLE_CNT_MAX) begin
          idle_cnt_d = idle_cnt_q + 10'd1;
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
      end else begin
        idle_tmr_d = idle_tmr_q + 16'd1;
        idle_cnt_d = idle_cnt_q;
      end
    end else begin
      idle_tmr_d = 16'd0;
      idle_cnt_d = 10'd0;
    end

    // A zero threshold still needs one full bit period of high line.
    if (idle_len == 10'd0) begin
      idle_thr_s = 10'd1;
    end else begin
      idle_thr_s = idle_len;
    end
    bus_idle_d = (idle_cnt_d >= idle_thr_s);

    if (bus_idle_d && !bus_idle_q && in_frame_q) begin
      fend_d     = 1'b1;
      in_frame_d = 1'b0;
      baud_sel_d = 1'b0;
    end else begin
      fend_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      break_q      <= 1'b0;
      ferr_q       <= 1'b0;
      fend_q       <= 1'b0;
      bus_idle_q   <= 1'b0;
      crc_q        <= CRC_INIT;
      in_frame_q   <= 1'b0;
      baud_sel_q   <= 1'b0;
      idle_tmr_q   <= 16'd0;
      idle_cnt_q   <= 10'd0;
      rx_prev_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      break_q      <= break_d;
      ferr_q       <= ferr_d;
      fend_q       <= fend_d;
      bus_idle_q   <= bus_idle_d;
      crc_q        <= crc_d;
      in_frame_q   <= in_frame_d;
      baud_sel_q   <= baud_sel_d;
      idle_tmr_q   <= idle_tmr_d;
      idle_cnt_q   <= idle_cnt_d;
      rx_prev_q    <= rx_s;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign break_det  = break_q;
  assign frame_err  = ferr_q;
  assign frame_end  = fend_q;
  assign bus_idle   = bus_idle_q;
  assign crc_data   = crc_q;

endmodule

// File: tb/tb_rx_des_frame.sv
// Directed testbench for rx_des_frame: drives bit-accurate UART waveforms on
// rx and compares strobe counts, received bytes, bus_idle and CRC against
// hand-computed values.
module tb_rx_des_frame;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [15:0] div_ls;
  logic [15:0] div_hs;
  logic [9:0]  idle_len;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        break_det;
  logic        frame_err;
  logic        frame_end;
  logic        bus_idle;
  logic [15:0] crc_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_byte = 0;
  int n_brk = 0;
  int n_ferr = 0;
  int n_fend = 0;
  logic [7:0] byte_log [0:7];

  rx_des_frame #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .div_ls     (div_ls),
    .div_hs     (div_hs),
    .idle_len   (idle_len),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .break_det  (break_det),
    .frame_err  (frame_err),
    .frame_end  (frame_end),
    .bus_idle   (bus_idle),
    .crc_data   (crc_data)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (byte_valid === 1'b1) begin
        if (n_byte < 8) byte_log[n_byte[2:0]] = byte_data;
        n_byte = n_byte + 1;
      end
      if (break_det === 1'b1) n_brk = n_brk + 1;
      if (frame_err === 1'b1) n_ferr = n_ferr + 1;
      if (frame_end === 1'b1) n_fend = n_fend + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_byte = 0;
    n_brk  = 0;
    n_ferr = 0;
    n_fend = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int per, input logic stop_b);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop_b;
    repeat (per) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (bus_idle !== 1'b1 && k < budget) begin
      @(negedge clk);
      k = k + 1;
    end
    chk_eq(tag, {31'd0, bus_idle}, 32'd1);
  endtask

  task automatic wait_fend(input string tag, input int budget);
    int k;
    k = 0;
    while (n_fend == 0 && k < budget) begin
      @(negedge clk);
      k = k + 1;
    end
    repeat (2) @(negedge clk);
    chk_eq(tag, n_fend, 32'd1);
  endtask

  initial begin
    logic [7:0] v;
    reset_n  = 1'b0;
    rx       = 1'b1;
    div_ls   = 16'd9;
    div_hs   = 16'd3;
    idle_len = 10'd2;
    repeat (3) @(negedge clk);
    chk_eq("rst_byte_data", {24'd0, byte_data}, 32'h0);
    chk_eq("rst_strobes", {28'd0, byte_valid, break_det, frame_err, frame_end}, 32'h0);
    chk_eq("rst_bus_idle", {31'd0, bus_idle}, 32'h0);
    chk_eq("rst_crc", {16'd0, crc_data}, 32'hFFFF);
    reset_n = 1'b1;
    wait_idle("init_idle", 100);

    // Single byte at low speed, then frame end on idle.
    clr_counts();
    send_byte(8'h55, 10, 1'b1);
    wait_fend("t1_fend", 400);
    chk_eq("t1_nbyte", n_byte, 32'd1);
    chk_eq("t1_data", {24'd0, byte_log[0]}, 32'h55);
    chk_eq("t1_bus_idle", {31'd0, bus_idle}, 32'd1);

    // 3-clock low glitch: false start, no strobes.
    clr_counts();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("t2_idle_drop", {31'd0, bus_idle}, 32'd0);
    repeat (10) @(negedge clk);
    chk_eq("t2_idle_held_low", {31'd0, bus_idle}, 32'd0);
    wait_idle("t2_idle_back", 60);
    chk_eq("t2_nstrobe", n_byte + n_brk + n_ferr + n_fend, 32'd0);

    // Break: 10 bit periods low.
    clr_counts();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk_eq("t3_nbrk", n_brk, 32'd1);
    chk_eq("t3_nbyte", n_byte, 32'd0);
    chk_eq("t3_nferr", n_ferr, 32'd0);
    wait_idle("t3_idle", 100);
    clr_counts();
    send_byte(8'hC3, 10, 1'b1);
    wait_fend("t3_fend", 400);
    chk_eq("t3_after_nbyte", n_byte, 32'd1);
    chk_eq("t3_after_data", {24'd0, byte_log[0]}, 32'hC3);

    // Two bytes: first at low speed, second at high speed; CRC check.
    div_ls = 16'd15;
    wait_idle("t4_idle", 100);
    clr_counts();
    send_byte(8'h01, 16, 1'b1);
    send_byte(8'h02, 4, 1'b1);
    wait_fend("t4_fend", 300);
    chk_eq("t4_nbyte", n_byte, 32'd2);
    chk_eq("t4_data0", {24'd0, byte_log[0]}, 32'h01);
    chk_eq("t4_data1", {24'd0, byte_log[1]}, 32'h02);
    chk_eq("t4_crc", {16'd0, crc_data}, 32'hE181);

    // Framing error, then a good byte.
    div_ls = 16'd9;
    wait_idle("t5_idle", 100);
    clr_counts();
    send_byte(8'hA5, 10, 1'b0);
    repeat (30) @(negedge clk);
    chk_eq("t5_nferr", n_ferr, 32'd1);
    chk_eq("t5_nbyte", n_byte, 32'd0);
    chk_eq("t5_nbrk", n_brk, 32'd0);
    send_byte(8'h3C, 10, 1'b1);
    wait_fend("t5_fend", 400);
    chk_eq("t5_after_nbyte", n_byte, 32'd1);
    chk_eq("t5_after_data", {24'd0, byte_log[0]}, 32'h3C);

    // Reset during bit 4 of a byte.
    wait_idle("t6_idle", 100);
    clr_counts();
    v  = 8'h96;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = v[i];
      repeat (10) @(negedge clk);
    end
    rx = v[4];
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    rx      = 1'b1;
    @(negedge clk);
    chk_eq("t6_rst_data", {24'd0, byte_data}, 32'h0);
    chk_eq("t6_rst_strobes", {28'd0, byte_valid, break_det, frame_err, frame_end}, 32'h0);
    chk_eq("t6_rst_bus_idle", {31'd0, bus_idle}, 32'h0);
    chk_eq("t6_rst_crc", {16'd0, crc_data}, 32'hFFFF);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_idle("t6_idle_after", 100);
    clr_counts();
    send_byte(8'h96, 10, 1'b1);
    wait_fend("t6_fend", 400);
    chk_eq("t6_nbyte", n_byte, 32'd1);
    chk_eq("t6_data", {24'd0, byte_log[0]}, 32'h96);
    chk_eq("t6_nerr", n_brk + n_ferr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
